// File: rtl/serial_bram_pkg.sv
// Shared constants for the UART-to-BRAM burst writer:
// one-hot state encodings and the supported word-width range.
package serial_bram_pkg;

  localparam int ST_W = 4;

  localparam int I_IDLE    = 0;
  localparam int I_COLLECT = 1;
  localparam int I_WRITE   = 2;
  localparam int I_DONE    = 3;

  localparam logic [ST_W-1:0] S_IDLE    = 4'b0001;
  localparam logic [ST_W-1:0] S_COLLECT = 4'b0010;
  localparam logic [ST_W-1:0] S_WRITE   = 4'b0100;
  localparam logic [ST_W-1:0] S_DONE    = 4'b1000;

  localparam int BPW_MIN = 1;
  localparam int BPW_MAX = 8;

endpackage

// File: rtl/serial_burst_to_bram_if.sv
// UART RX-FIFO pop side and BRAM write side of the burst writer.
// The master is the burst engine; the slave is the surrounding fabric.
interface serial_burst_to_bram_if #(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 9
);

  logic [7:0]                  uart_data_in;
  logic                        uart_data_present;
  logic                        uart_data_read;
  logic [8*BYTES_PER_WORD-1:0] bram_data;
  logic                        bram_we;
  logic [ADDR_W-1:0]           bram_addr;
  logic [BYTES_PER_WORD-1:0]   bram_we_bytes;

  modport master (
    input  uart_data_in,
    input  uart_data_present,
    output uart_data_read,
    output bram_data,
    output bram_we,
    output bram_addr,
    output bram_we_bytes
  );

  modport slave (
    output uart_data_in,
    output uart_data_present,
    input  uart_data_read,
    input  bram_data,
    input  bram_we,
    input  bram_addr,
    input  bram_we_bytes
  );

endinterface

// File: rtl/lane_arbiter.sv
// Picks the highest set bit of a lane vector as a one-hot result.
// An all-zero input yields an all-zero output.
module lane_arbiter #(
  parameter int W = 4
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] hot
);

  always_comb begin
    hot = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        hot    = '0;
        hot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_burst_to_bram.sv
// Assembles UART bytes into masked BRAM words, MSB lane first,
// and writes a burst of them to consecutive addresses.
module serial_burst_to_bram
  import serial_bram_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 9,
  parameter int LEN_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          word_count,
  input  logic [BYTES_PER_WORD-1:0] byte_mask,
  output logic                      busy,
  output logic                      done,
  output logic [LEN_W-1:0]          words_done,
  serial_burst_to_bram_if.master    bus
);

  localparam int BPW = BYTES_PER_WORD;

  if (BPW < BPW_MIN || BPW > BPW_MAX) begin : g_bpw_range
    $error("BYTES_PER_WORD out of range");
  end

  logic [ST_W-1:0]   state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [BPW-1:0]    mask;
  logic [BPW-1:0]    lane;
  logic [BPW-1:0]    top;
  logic [BPW-1:0]    rest;
  logic [8*BPW-1:0]  word;
  logic              pop;

  // In IDLE the first lane comes from the incoming mask, later from the latched one
  lane_arbiter #(.W(BPW)) u_top (
    .vec (state[I_IDLE] ? byte_mask : mask),
    .hot (top)
  );

  lane_arbiter #(.W(BPW)) u_rest (
    .vec (mask & (lane - BPW'(1))),
    .hot (rest)
  );

  assign pop  = state[I_COLLECT] & bus.uart_data_present & ~abort;
  assign busy = ~state[I_IDLE];
  assign done = state[I_DONE];

  assign bus.uart_data_read = pop;
  assign bus.bram_we        = state[I_WRITE];
  assign bus.bram_we_bytes  = state[I_WRITE] ? mask : '0;
  assign bus.bram_data      = word;
  assign bus.bram_addr      = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      cnt        <= '0;
      mask       <= '0;
      lane       <= '0;
      word       <= '0;
      words_done <= '0;
    end else begin
      unique case (1'b1)
        state[I_IDLE]: begin
          if (start) begin
            addr       <= base_addr;
            cnt        <= word_count;
            mask       <= byte_mask;
            lane       <= top;
            word       <= '0;
            words_done <= '0;
            if (word_count == '0 || byte_mask == '0)
              state <= S_DONE;
            else
              state <= S_COLLECT;
          end
        end
        state[I_COLLECT]: begin
          if (abort) begin
            word  <= '0;
            state <= S_DONE;
          end else if (bus.uart_data_present) begin
            for (int i = 0; i < BPW; i++)
              if (lane[i]) word[8*i +: 8] <= bus.uart_data_in;
            if (rest == '0)
              state <= S_WRITE;
            else
              lane <= rest;
          end
        end
        state[I_WRITE]: begin
          words_done <= words_done + LEN_W'(1);
          if (words_done + LEN_W'(1) == cnt || abort) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            word  <= '0;
            lane  <= top;
            state <= S_COLLECT;
          end
        end
        state[I_DONE]: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_burst_to_bram.md
SERIAL_BURST_TO_BRAM -- requirements
Module: serial_burst_to_bram

Interface
REQ-001 SHALL take parameter BYTES_PER_WORD, default 4, giving BRAM word width in bytes (range 1..8).
REQ-002 SHALL take parameter ADDR_W, default 9, giving BRAM address width.
REQ-003 SHALL take parameter LEN_W, default 8, giving burst word-count width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin burst; sampled only in IDLE.
REQ-007 abort  in  1  terminate burst early.
REQ-008 base_addr  in  ADDR_W  first BRAM word address.
REQ-009 word_count  in  LEN_W  number of words in burst.
REQ-010 byte_mask  in  BYTES_PER_WORD  lanes to fill per word.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 words_done  out  LEN_W  words written in current/last burst.
REQ-014 uart_data_in  in  8  received byte.
REQ-015 uart_data_present  in  1  RX FIFO non-empty.
REQ-016 uart_data_read  out  1  one-cycle pop strobe.
REQ-017 bram_data  out  8*BYTES_PER_WORD  assembled word.
REQ-018 bram_we  out  1  write strobe.
REQ-019 bram_addr  out  ADDR_W  write address.
REQ-020 bram_we_bytes  out  BYTES_PER_WORD  per-lane write enable.

Function
REQ-021 FSM states SHALL be IDLE, COLLECT, WRITE, DONE, one-hot.
REQ-022 IDLE: start=1 SHALL latch base_addr, word_count, byte_mask, clear assembly register and words_done; go to DONE if word_count=0 or byte_mask=0, else COLLECT with lane pointer at highest set mask bit.
REQ-023 COLLECT: uart_data_read SHALL equal uart_data_present (combinational), abort=0; each popped byte SHALL load the current lane of the assembly register that same edge.
REQ-024 Lanes SHALL fill from highest set mask bit down to lowest; unmasked lanes hold 0.
REQ-025 After the lowest set lane is filled, next state SHALL be WRITE; otherwise pointer moves to next lower set bit and stays COLLECT.
REQ-026 WRITE: bram_we=1 for exactly one cycle, bram_addr=current address, bram_we_bytes=latched mask, bram_data=assembled word; words_done increments.
REQ-027 After WRITE: if words_done reaches word_count go to DONE; else address+1 modulo 2^ADDR_W, clear assembly register, pointer to highest set lane, go COLLECT.
REQ-028 DONE: done=1 one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-029 abort in COLLECT SHALL suppress uart_data_read, discard partial word, go DONE next edge.
REQ-030 abort in WRITE SHALL let the write complete, then go DONE.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 bram_we, uart_data_read, done SHALL be 0 outside their states.
REQ-033 Throughput: one byte per cycle when uart_data_present stays high; k-lane word written k+1 cycles after first pop.

Reset
REQ-034 rst_n low SHALL immediately force IDLE; busy, done, bram_we, uart_data_read, bram_we_bytes, bram_data, bram_addr, words_done all 0.
REQ-035 Reset mid-burst SHALL drop the burst with no further BRAM write or UART pop.

Structure
REQ-036 Package serial_bram_pkg SHALL hold state encodings and BYTES_PER_WORD range limits.
REQ-037 Sub-module lane_arbiter SHALL give one-hot highest set bit of a BYTES_PER_WORD vector (zero in, zero out).

Verification
REQ-038 Defaults, base_addr=0x010, word_count=2, mask=4'b1111, bytes 11..18 streamed -> writes 0x11121314@0x010, 0x15161718@0x011, we_bytes=1111, done after second write, words_done=2.
REQ-039 mask=4'b0101, word_count=1, bytes AA,BB -> one write 0x00AA00BB, we_bytes=0101, exactly two pops.
REQ-040 base_addr=0x1FF, word_count=2, mask=0001 -> writes at 0x1FF then 0x000.
REQ-041 word_count=3, abort after 5 bytes of mask 1111 -> one write at base only, done pulse, words_done=1, no pop during abort.
REQ-042 word_count=0 -> done two cycles after start, no pop, no write; rst_n low during COLLECT -> all outputs 0 immediately.
REQ-043 uart_data_present toggled 1-0 randomly -> data unchanged vs. REQ-038, pops equal bytes consumed.
